// File: rtl/i_deser_ddr_pkg.sv
// Shared definitions for the input deserializer: rate encodings, width bounds and rate-derived sizing.
// Combinational helpers only; no latency, no backpressure.
package i_deser_ddr_pkg;

    typedef enum logic {
        RATE_SDR = 1'b0,
        RATE_DDR = 1'b1
    } rate_e;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 10;

    typedef struct packed {
        logic [1:0] bits;
        logic [3:0] groups;
    } rate_cfg_t;

    function automatic rate_e decode_rate(input logic [23:0] rate);
        return (rate == "DDR") ? RATE_DDR : RATE_SDR;
    endfunction

    function automatic logic is_legal(input int width, input logic [23:0] rate);
        if (rate != "DDR" && rate != "SDR") return 1'b0;
        if (width < WIDTH_MIN || width > WIDTH_MAX) return 1'b0;
        if (rate == "DDR" && (width % 2) != 0) return 1'b0;
        return 1'b1;
    endfunction

    // bits = B (bits captured per C period), groups = WIDTH/B shifts per word
    function automatic rate_cfg_t rate_cfg(input int width, input logic [23:0] rate);
        rate_cfg_t cfg;
        cfg.bits   = (decode_rate(rate) == RATE_DDR) ? 2'd2 : 2'd1;
        cfg.groups = 4'(width / int'(cfg.bits));
        return cfg;
    endfunction

endpackage

// File: rtl/i_deser_capture.sv
// Pin capture: d_r on rising C, d_f on falling C (DDR), plus the started flag; B bits and a shift strobe out.
// Outputs are registers gated by E combinationally; E=0 holds every register (no backpressure).
module i_deser_capture #(
    parameter int B = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_d,
    input  logic         i_en,
    output logic [B-1:0] o_bits,
    output logic         o_shift
);

    logic r_d_r;
    logic r_started;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d_r     <= 1'b0;
            r_started <= 1'b0;
        end else if (i_en) begin
            r_d_r     <= i_d;
            r_started <= 1'b1;
        end
    end

    // The first enabled edge only loads d_r; shifting starts on the one after.
    assign o_shift = i_en && r_started;

    generate
        if (B == 2) begin : g_ddr
            logic r_d_f;

            always_ff @(negedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_d_f <= 1'b0;
                end else if (i_en) begin
                    r_d_f <= i_d;
                end
            end

            assign o_bits = {r_d_r, r_d_f};
        end else begin : g_sdr
            assign o_bits = r_d_r;
        end
    endgenerate

endmodule

// File: rtl/i_deser_ddr.sv
// SDR/DDR input deserializer with bitslip; word j presented after enabled rising edge 1+(j+2)*WIDTH/B.
// DATA_VALID is a one-cycle strobe; E=0 freezes all state and suppresses the strobe (no backpressure).
module i_deser_ddr
    import i_deser_ddr_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter logic [23:0] DATA_RATE = "DDR"
) (
    input  logic             C,
    input  logic             R,
    input  logic             D,
    input  logic             E,
    input  logic             BITSLIP,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID
);

    localparam rate_cfg_t  CFG    = rate_cfg(WIDTH, DATA_RATE);
    localparam int         B      = int'(CFG.bits);
    localparam int         GROUPS = int'(CFG.groups);
    localparam logic [3:0] LAST   = 4'(GROUPS - 1);
    localparam logic [3:0] OMAX   = 4'(WIDTH - 1);

    if (!is_legal(WIDTH, DATA_RATE)) begin : g_bad_param
        $fatal(1, "i_deser_ddr: illegal WIDTH/DATA_RATE combination");
    end

    logic [B-1:0]       w_bits;
    logic               w_shift;
    logic [2*WIDTH-1:0] r_hist;
    logic [2*WIDTH-1:0] w_hist_nxt;
    logic [WIDTH-1:0]   w_word;
    logic [3:0]         r_cnt;
    logic [3:0]         r_off;
    logic               r_primed;
    logic               r_bs;
    logic               w_wrap;
    logic               w_slip;

    i_deser_capture #(
        .B(B)
    ) u_capture (
        .i_clk  (C),
        .i_rst_n(R),
        .i_d    (D),
        .i_en   (E),
        .o_bits (w_bits),
        .o_shift(w_shift)
    );

    assign w_hist_nxt = (r_hist << B) | (2*WIDTH)'(w_bits);
    // Window of WIDTH bits starting o bits below the oldest bit of the post-shift history.
    assign w_word     = WIDTH'((w_hist_nxt << r_off) >> WIDTH);
    assign w_wrap     = w_shift && (r_cnt == LAST);
    assign w_slip     = E && BITSLIP && !r_bs;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_hist     <= '0;
            r_cnt      <= '0;
            r_off      <= '0;
            r_primed   <= 1'b0;
            r_bs       <= 1'b0;
            Q          <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (w_shift) begin
                r_hist <= w_hist_nxt;
                r_cnt  <= w_wrap ? 4'd0 : r_cnt + 4'd1;
            end
            // The first completion only fills the history; words start from the second.
            if (w_wrap) begin
                r_primed <= 1'b1;
                if (r_primed) begin
                    Q          <= w_word;
                    DATA_VALID <= 1'b1;
                end
            end
            if (E) begin
                r_bs <= BITSLIP;
            end
            if (w_slip) begin
                r_off <= (r_off == OMAX) ? 4'd0 : r_off + 4'd1;
            end
        end
    end

endmodule
